// File: rtl/tomasulo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package    : tomasulo_pkg                                          |
// | Description: Shared types and defaults for the ALU reservation     |
// |              station (opcodes, default widths, entry record).      |
// | Revision   : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
package tomasulo_pkg;

   localparam int XLEN_DEFAULT  = 32;
   localparam int TAG_W_DEFAULT = 4;

   typedef enum logic [3:0] {
      ALU_ADD = 4'b0000,
      ALU_SUB = 4'b0001,
      ALU_AND = 4'b0010,
      ALU_OR  = 4'b0011,
      ALU_XOR = 4'b0100,
      ALU_SLL = 4'b0101,
      ALU_SRL = 4'b0110,
      ALU_SLT = 4'b0111
   } alu_op_e;

   typedef struct packed {
      logic                     valid;
      alu_op_e                  op;
      logic [XLEN_DEFAULT-1:0]  vj;
      logic [XLEN_DEFAULT-1:0]  vk;
      logic [TAG_W_DEFAULT-1:0] qj;
      logic [TAG_W_DEFAULT-1:0] qk;
      logic                     qj_pend;
      logic                     qk_pend;
      logic [TAG_W_DEFAULT-1:0] dest;
   } rs_entry_t;

endpackage : tomasulo_pkg
`default_nettype wire

// File: rtl/alu_rs_age_select.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module     : alu_rs_age_select                                     |
// | Description: Age matrix for the reservation station. Tracks the    |
// |              relative order of live entries and grants the oldest  |
// |              eligible one (one-hot).                               |
// | Revision   : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
module alu_rs_age_select import tomasulo_pkg::*; #(
   parameter int NUM_ENTRIES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_flush,
   input  logic [NUM_ENTRIES-1:0] i_issue_oh,
   input  logic [NUM_ENTRIES-1:0] i_free_oh,
   input  logic [NUM_ENTRIES-1:0] i_valid,
   input  logic [NUM_ENTRIES-1:0] i_elig,
   output logic [NUM_ENTRIES-1:0] o_grant
);

   // r_age[i][j] set means entry i is older than entry j
   logic [NUM_ENTRIES-1:0] r_age [NUM_ENTRIES];

   // Maintain the matrix: freed rows/columns clear, a new entry is younger than every live one
   always_ff @(posedge clk) begin
      if (!rst_n || i_flush) begin
         for (int i = 0; i < NUM_ENTRIES; i++) r_age[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            for (int j = 0; j < NUM_ENTRIES; j++) begin
               if (i_free_oh[i] || i_free_oh[j])
                  r_age[i][j] <= 1'b0;
               else if (i_issue_oh[i])
                  r_age[i][j] <= 1'b0;
               else if (i_issue_oh[j])
                  r_age[i][j] <= i_valid[i];
            end
         end
      end
   end

   // An eligible entry wins when no other eligible entry is older than it
   always_comb begin
      o_grant = i_elig;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         for (int j = 0; j < NUM_ENTRIES; j++) begin
            if (j != i && i_elig[j] && r_age[j][i]) o_grant[i] = 1'b0;
         end
      end
   end

endmodule : alu_rs_age_select
`default_nettype wire

// File: rtl/alu_rs.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module     : alu_rs                                                |
// | Description: Reservation station in front of the integer ALU.     |
// |              Buffers issued ops, snoops the CDB for operands,      |
// |              dispatches the oldest ready op and holds the result   |
// |              in a valid/ready output register.                     |
// |              Optional macro ALU_RS_PERF_CNT_EN adds perf counters. |
// | Revision   : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
module alu_rs import tomasulo_pkg::*; #(
   parameter int NUM_ENTRIES = 4,
   parameter int TAG_W       = TAG_W_DEFAULT,
   parameter int XLEN        = XLEN_DEFAULT
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               flush,
   input  logic                               issue_valid,
   output logic                               issue_ready,
   input  logic [3:0]                         issue_op,
   input  logic [XLEN-1:0]                    issue_vj,
   input  logic [TAG_W-1:0]                   issue_qj,
   input  logic                               issue_qj_pend,
   input  logic [XLEN-1:0]                    issue_vk,
   input  logic [TAG_W-1:0]                   issue_qk,
   input  logic                               issue_qk_pend,
   input  logic [TAG_W-1:0]                   issue_dest,
   input  logic                               cdb_valid,
   input  logic [TAG_W-1:0]                   cdb_tag,
   input  logic [XLEN-1:0]                    cdb_data,
   output logic [XLEN-1:0]                    alu_a,
   output logic [XLEN-1:0]                    alu_b,
   output logic [3:0]                         alu_op,
   input  logic [XLEN-1:0]                    alu_result,
   output logic                               res_valid,
   input  logic                               res_ready,
   output logic [TAG_W-1:0]                   res_tag,
   output logic [XLEN-1:0]                    res_data,
   output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy
`ifdef ALU_RS_PERF_CNT_EN
  ,output logic [31:0]                        perf_dispatch,
   output logic [31:0]                        perf_stall
`endif
);

   localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
   localparam int OCC_W = $clog2(NUM_ENTRIES+1);

   logic [NUM_ENTRIES-1:0] r_valid;
   logic [NUM_ENTRIES-1:0] r_qj_pend;
   logic [NUM_ENTRIES-1:0] r_qk_pend;
   alu_op_e                r_op   [NUM_ENTRIES];
   logic [XLEN-1:0]        r_vj   [NUM_ENTRIES];
   logic [XLEN-1:0]        r_vk   [NUM_ENTRIES];
   logic [TAG_W-1:0]       r_qj   [NUM_ENTRIES];
   logic [TAG_W-1:0]       r_qk   [NUM_ENTRIES];
   logic [TAG_W-1:0]       r_dest [NUM_ENTRIES];

   logic                   r_res_valid;
   logic [TAG_W-1:0]       r_res_tag;
   logic [XLEN-1:0]        r_res_data;

   logic [NUM_ENTRIES-1:0] w_free_oh;
   logic [NUM_ENTRIES-1:0] w_alloc_oh;
   logic [NUM_ENTRIES-1:0] w_elig;
   logic [NUM_ENTRIES-1:0] w_grant;
   logic [NUM_ENTRIES-1:0] w_free_dispatch;
   logic [IDX_W-1:0]       w_sel_idx;
   logic [OCC_W-1:0]       w_occ;
   logic                   w_issue_fire;
   logic                   w_any_sel;
   logic                   w_dispatch;
   logic                   w_iss_qj_hit;
   logic                   w_iss_qk_hit;

   assign issue_ready     = ~&r_valid;
   assign w_issue_fire    = issue_valid & issue_ready;
   assign w_alloc_oh      = w_free_oh & {NUM_ENTRIES{w_issue_fire}};
   assign w_elig          = r_valid & ~r_qj_pend & ~r_qk_pend;
   assign w_any_sel       = |w_elig;
   assign w_dispatch      = w_any_sel & (~r_res_valid | res_ready);
   assign w_free_dispatch = w_grant & {NUM_ENTRIES{w_dispatch}};
   assign w_iss_qj_hit    = issue_qj_pend & cdb_valid & (cdb_tag == issue_qj);
   assign w_iss_qk_hit    = issue_qk_pend & cdb_valid & (cdb_tag == issue_qk);

   // Lowest-index free slot receives the next issue
   always_comb begin
      w_free_oh = '0;
      for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
         if (!r_valid[i]) begin
            w_free_oh    = '0;
            w_free_oh[i] = 1'b1;
         end
      end
   end

   // Encode the one-hot grant into an index for the operand mux
   always_comb begin
      w_sel_idx = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (w_grant[i]) w_sel_idx = IDX_W'(i);
      end
   end

   // Count live entries
   always_comb begin
      w_occ = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) w_occ = w_occ + OCC_W'(r_valid[i]);
   end

   assign occupancy = w_occ;
   assign alu_a     = w_any_sel ? r_vj[w_sel_idx] : '0;
   assign alu_b     = w_any_sel ? r_vk[w_sel_idx] : '0;
   assign alu_op    = w_any_sel ? r_op[w_sel_idx] : 4'b0000;
   assign res_valid = r_res_valid;
   assign res_tag   = r_res_tag;
   assign res_data  = r_res_data;

   alu_rs_age_select #(
      .NUM_ENTRIES (NUM_ENTRIES)
   ) u_age_select (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_flush    (flush),
      .i_issue_oh (w_alloc_oh),
      .i_free_oh  (w_free_dispatch),
      .i_valid    (r_valid),
      .i_elig     (w_elig),
      .o_grant    (w_grant)
   );

   // Entry storage: free on dispatch, fill on issue (with same-cycle CDB capture), wake on CDB match
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid   <= '0;
         r_qj_pend <= '0;
         r_qk_pend <= '0;
      end else if (flush) begin
         r_valid <= '0;
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_free_dispatch[i]) begin
               r_valid[i] <= 1'b0;
            end else if (w_alloc_oh[i]) begin
               r_valid[i]   <= 1'b1;
               r_op[i]      <= alu_op_e'(issue_op);
               r_qj[i]      <= issue_qj;
               r_qk[i]      <= issue_qk;
               r_dest[i]    <= issue_dest;
               r_vj[i]      <= w_iss_qj_hit ? cdb_data : issue_vj;
               r_vk[i]      <= w_iss_qk_hit ? cdb_data : issue_vk;
               r_qj_pend[i] <= issue_qj_pend & ~w_iss_qj_hit;
               r_qk_pend[i] <= issue_qk_pend & ~w_iss_qk_hit;
            end else if (r_valid[i] && cdb_valid) begin
               if (r_qj_pend[i] && cdb_tag == r_qj[i]) begin
                  r_vj[i]      <= cdb_data;
                  r_qj_pend[i] <= 1'b0;
               end
               if (r_qk_pend[i] && cdb_tag == r_qk[i]) begin
                  r_vk[i]      <= cdb_data;
                  r_qk_pend[i] <= 1'b0;
               end
            end
         end
      end
   end

   // Result register: load on dispatch, hold under backpressure, drop once accepted
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_res_valid <= 1'b0;
         r_res_tag   <= '0;
         r_res_data  <= '0;
      end else if (flush) begin
         r_res_valid <= 1'b0;
      end else if (w_dispatch) begin
         r_res_valid <= 1'b1;
         r_res_tag   <= r_dest[w_sel_idx];
         r_res_data  <= alu_result;
      end else if (r_res_valid && res_ready) begin
         r_res_valid <= 1'b0;
      end
   end

`ifdef ALU_RS_PERF_CNT_EN
   logic [31:0] r_perf_dispatch;
   logic [31:0] r_perf_stall;

   // Free-running event counters; flush does not clear them
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_perf_dispatch <= '0;
         r_perf_stall    <= '0;
      end else begin
         if (w_dispatch && !flush)
            r_perf_dispatch <= r_perf_dispatch + 32'd1;
         if (w_any_sel && r_res_valid && !res_ready)
            r_perf_stall <= r_perf_stall + 32'd1;
      end
   end

   assign perf_dispatch = r_perf_dispatch;
   assign perf_stall    = r_perf_stall;
`endif

endmodule : alu_rs
`default_nettype wire

// File: tb/tb_alu_rs.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module     : tb_alu_rs                                             |
// | Description: Self-checking bench for alu_rs with a behavioural ALU |
// |              and a queue-based reference model of the station.     |
// | Revision   : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
module tb_alu_rs;

   localparam int NE = 4;

   logic        clk = 1'b0;
   logic        rst_n, flush, issue_valid, issue_ready;
   logic [3:0]  issue_op;
   logic [31:0] issue_vj, issue_vk;
   logic [3:0]  issue_qj, issue_qk, issue_dest;
   logic        issue_qj_pend, issue_qk_pend;
   logic        cdb_valid;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [3:0]  alu_op;
   logic        res_valid, res_ready;
   logic [3:0]  res_tag;
   logic [31:0] res_data;
   logic [2:0]  occupancy;
`ifdef ALU_RS_PERF_CNT_EN
   logic [31:0] perf_dispatch, perf_stall;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   alu_rs #(.NUM_ENTRIES(NE), .TAG_W(4), .XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
      .issue_vj(issue_vj), .issue_qj(issue_qj), .issue_qj_pend(issue_qj_pend),
      .issue_vk(issue_vk), .issue_qk(issue_qk), .issue_qk_pend(issue_qk_pend),
      .issue_dest(issue_dest), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
      .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag), .res_data(res_data),
      .occupancy(occupancy)
`ifdef ALU_RS_PERF_CNT_EN
     ,.perf_dispatch(perf_dispatch), .perf_stall(perf_stall)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return a << b[4:0];
         4'd6:    return a >> b[4:0];
         4'd7:    return {31'b0, ($signed(a) < $signed(b))};
         default: return 32'd0;
      endcase
   endfunction

   // Behavioural ALU seen by the station
   assign alu_result = alu_f(alu_op, alu_a, alu_b);

   // Reference model: queue kept in issue order, so the head-most ready entry is the oldest
   typedef struct {
      logic [3:0]  op;
      logic [31:0] a, b;
      logic [3:0]  qa, qb, dest;
      bit          pa, pb;
   } m_ent_t;

   m_ent_t      mq[$];
   bit          m_rv = 1'b0;
   logic [3:0]  m_rt = '0;
   logic [31:0] m_rd = '0;

   task automatic model_step();
      int     sel;
      bit     acc;
      m_ent_t e;
      if (!rst_n) begin
         mq.delete(); m_rv = 1'b0; m_rt = '0; m_rd = '0;
         return;
      end
      if (flush) begin
         mq.delete(); m_rv = 1'b0;
         return;
      end
      acc = issue_valid && (mq.size() < NE);
      sel = -1;
      foreach (mq[i]) if (sel < 0 && !mq[i].pa && !mq[i].pb) sel = i;
      if (sel >= 0 && (!m_rv || res_ready)) begin
         m_rd = alu_f(mq[sel].op, mq[sel].a, mq[sel].b);
         m_rt = mq[sel].dest;
         m_rv = 1'b1;
         mq.delete(sel);
      end else if (m_rv && res_ready) begin
         m_rv = 1'b0;
      end
      if (cdb_valid) begin
         foreach (mq[i]) begin
            if (mq[i].pa && mq[i].qa == cdb_tag) begin mq[i].a = cdb_data; mq[i].pa = 1'b0; end
            if (mq[i].pb && mq[i].qb == cdb_tag) begin mq[i].b = cdb_data; mq[i].pb = 1'b0; end
         end
      end
      if (acc) begin
         e.op = issue_op; e.qa = issue_qj; e.qb = issue_qk; e.dest = issue_dest;
         e.pa = issue_qj_pend; e.a = issue_vj;
         e.pb = issue_qk_pend; e.b = issue_vk;
         if (e.pa && cdb_valid && cdb_tag == issue_qj) begin e.pa = 1'b0; e.a = cdb_data; end
         if (e.pb && cdb_valid && cdb_tag == issue_qk) begin e.pb = 1'b0; e.b = cdb_data; end
         mq.push_back(e);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("model.res_valid", {31'b0, res_valid}, {31'b0, m_rv});
      if (m_rv) begin
         chk("model.res_tag", {28'b0, res_tag}, {28'b0, m_rt});
         chk("model.res_data", res_data, m_rd);
      end
      chk("model.occupancy", {29'b0, occupancy}, mq.size());
      chk("model.issue_ready", {31'b0, issue_ready}, {31'b0, (mq.size() < NE)});
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   task automatic set_issue(input logic [3:0] op, input logic [31:0] vj, input logic [3:0] qj, input bit pj,
                            input logic [31:0] vk, input logic [3:0] qk, input bit pk, input logic [3:0] dest);
      issue_valid = 1'b1; issue_op = op;
      issue_vj = vj; issue_qj = qj; issue_qj_pend = pj;
      issue_vk = vk; issue_qk = qk; issue_qk_pend = pk;
      issue_dest = dest;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_op = '0;
      issue_vj = '0; issue_vk = '0; issue_qj = '0; issue_qk = '0; issue_dest = '0;
      issue_qj_pend = 1'b0; issue_qk_pend = 1'b0;
      cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; res_ready = 1'b1;
      #1;

      // Reset held for two cycles
      tick(); tick();
      chk("reset.issue_ready", {31'b0, issue_ready}, 32'd1);
      chk("reset.res_valid", {31'b0, res_valid}, 32'd0);
      chk("reset.occupancy", {29'b0, occupancy}, 32'd0);
      rst_n = 1'b1;
      tick();

      // ADD 10+20, both ready: result two cycles after issue
      set_issue(4'd0, 32'd10, 4'd0, 1'b0, 32'd20, 4'd0, 1'b0, 4'd3);
      tick();
      issue_valid = 1'b0;
      chk("add.not_early", {31'b0, res_valid}, 32'd0);
      tick();
      chk("add.res_valid", {31'b0, res_valid}, 32'd1);
      chk("add.res_tag", {28'b0, res_tag}, 32'd3);
      chk("add.res_data", res_data, 32'd30);
      tick();

      // SUB with A pending on tag 5, woken by CDB
      set_issue(4'd1, 32'd0, 4'd5, 1'b1, 32'd30, 4'd0, 1'b0, 4'd1);
      tick();
      issue_valid = 1'b0;
      tick();
      chk("sub.waiting", {31'b0, res_valid}, 32'd0);
      cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_data = 32'd50;
      tick();
      cdb_valid = 1'b0;
      chk("sub.not_early", {31'b0, res_valid}, 32'd0);
      tick();
      chk("sub.res_tag", {28'b0, res_tag}, 32'd1);
      chk("sub.res_data", res_data, 32'd20);
      tick();

      // AND whose pending operand is broadcast in the issue cycle
      set_issue(4'd2, 32'd0, 4'd7, 1'b1, 32'h0F, 4'd0, 1'b0, 4'd2);
      cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_data = 32'hFF;
      tick();
      issue_valid = 1'b0; cdb_valid = 1'b0;
      tick();
      chk("and.res_valid", {31'b0, res_valid}, 32'd1);
      chk("and.res_data", res_data, 32'h0F);
      tick();

      // Fill all entries with pending ops; XOR and SLL wait on tag 9
      set_issue(4'd4, 32'd0, 4'd9, 1'b1, 32'h0F0F, 4'd0, 1'b0, 4'd4); tick();
      set_issue(4'd0, 32'd0, 4'd10, 1'b1, 32'd1, 4'd0, 1'b0, 4'd5);   tick();
      set_issue(4'd5, 32'd0, 4'd9, 1'b1, 32'd4, 4'd0, 1'b0, 4'd6);    tick();
      set_issue(4'd3, 32'd0, 4'd11, 1'b1, 32'd0, 4'd0, 1'b0, 4'd7);   tick();
      chk("full.issue_ready", {31'b0, issue_ready}, 32'd0);
      chk("full.occupancy", {29'b0, occupancy}, 32'd4);
      set_issue(4'd0, 32'd1, 4'd0, 1'b0, 32'd1, 4'd0, 1'b0, 4'd15);
      tick();
      chk("full.ignored", {29'b0, occupancy}, 32'd4);
      issue_valid = 1'b0; res_ready = 1'b0;
      cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'hFF00;
      tick();
      cdb_valid = 1'b0;
      tick();
      chk("order.first_tag", {28'b0, res_tag}, 32'd4);
      chk("order.first_data", res_data, 32'hF00F);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("stall.valid", {31'b0, res_valid}, 32'd1);
         chk("stall.tag", {28'b0, res_tag}, 32'd4);
         chk("stall.data", res_data, 32'hF00F);
         chk("stall.occupancy", {29'b0, occupancy}, 32'd3);
      end
      res_ready = 1'b1;
      tick();
      chk("order.second_tag", {28'b0, res_tag}, 32'd6);
      chk("order.second_data", res_data, 32'hFF000);

      // Flush with three live entries and a held result
      res_ready = 1'b0;
      set_issue(4'd0, 32'd0, 4'd12, 1'b1, 32'd0, 4'd0, 1'b0, 4'd9);
      tick();
      issue_valid = 1'b0;
      chk("preflush.occupancy", {29'b0, occupancy}, 32'd3);
      chk("preflush.res_valid", {31'b0, res_valid}, 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0; res_ready = 1'b1;
      chk("flush.occupancy", {29'b0, occupancy}, 32'd0);
      chk("flush.res_valid", {31'b0, res_valid}, 32'd0);
      set_issue(4'd0, 32'd1, 4'd0, 1'b0, 32'd1, 4'd0, 1'b0, 4'd8);
      tick();
      issue_valid = 1'b0;
      tick();
      chk("postflush.res_tag", {28'b0, res_tag}, 32'd8);
      chk("postflush.res_data", res_data, 32'd2);

      // Randomized traffic against the reference model
      for (int c = 0; c < 600; c++) begin
         issue_valid   = ($urandom_range(0, 9) < 6);
         issue_op      = 4'($urandom_range(0, 7));
         issue_vj      = $urandom;
         issue_vk      = $urandom;
         issue_qj      = 4'($urandom_range(0, 7));
         issue_qk      = 4'($urandom_range(0, 7));
         issue_qj_pend = ($urandom_range(0, 1) == 1);
         issue_qk_pend = ($urandom_range(0, 2) == 0);
         issue_dest    = 4'($urandom_range(0, 15));
         cdb_valid     = ($urandom_range(0, 9) < 4);
         cdb_tag       = 4'($urandom_range(0, 7));
         cdb_data      = $urandom;
         res_ready     = ($urandom_range(0, 9) < 7);
         flush         = ($urandom_range(0, 59) == 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_alu_rs
`default_nettype wire
